ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
Parametrised EX/MEM pipeline stage that replaces the plain edge-sampled EX/MEM register. It carries EX results and control bits into MEM through a 2-entry skid buffer, using a valid/ready handshake on both sides. It supports synchronous flush for branch and exception squash, and produces the branch-taken select (pcsrc) and MEM-stage forwarding info. It sits between the ALU/branch-adder outputs and the data memory / MEM_WB stage.

Parameters:
DATA_W, 64, width of addsum, alures and rd2 datapaths
REG_ADDR_W, 5, width of destination register index
BRANCH_GATED, 1, 1: pcsrc is qualified by out_valid; 0: pcsrc = branchout & zerout only

Ports:
clk  in  1  clock; all state updates on the rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous squash of all held entries and of any input offered this cycle
in_valid  in  1  EX presents a transaction
in_ready  out  1  stage can accept a transaction (registered: !skid_valid)
addsum  in  DATA_W  branch target from EX adder
alures  in  DATA_W  ALU result
zero  in  1  ALU zero flag
rd2  in  DATA_W  store data
rd  in  REG_ADDR_W  destination register index
regwrite, memtoreg, branch, memread, memwrite  in  1 each  control bits
out_valid  out  1  MEM-side transaction valid
out_ready  in  1  MEM/downstream accepts
addsumout, aluresout, rd2out  out  DATA_W  registered data
zerout  out  1  registered zero flag
rdout  out  REG_ADDR_W  registered destination
regwriteout, memtoregout, branchout, memreadout, memwriteout  out  1 each  registered control, gated
pcsrc  out  1  branch taken select to PC mux
fwd_rd  out  REG_ADDR_W  forwarding index (= rdout)
fwd_en  out  1  out_valid & regwriteout & (rdout != 0)

Behaviour:
- State: main register (main_valid + payload), skid register (skid_valid + payload). out_valid = main_valid.
- Reset (reset_n low, async): main_valid=0, skid_valid=0, in_ready=1, all payload fields 0, so every output is 0. Release is synchronous to clk in the parent; the stage itself only samples reset_n asynchronously.
- Accept: in_fire = in_valid & in_ready. Drain: out_fire = out_valid & out_ready.
- Main load condition: main empty OR out_fire.
  - skid_valid: main <= skid; skid <= input if in_fire, else skid_valid <= 0.
  - else if in_fire: main <= input.
  - else: main_valid <= 0.
- Main not loadable (full, not draining) and in_fire: skid <= input, skid_valid <= 1.
- in_ready is registered = !skid_valid; the stage never drops a fire. Worst case 2 entries held.
- Latency: 1 cycle from in_fire to out_valid when empty. Throughput 1/cycle with out_ready held high.
- Order preserved strictly FIFO (skid entry always older than the concurrent input).
- flush=1 at a rising edge: main_valid <= 0, skid_valid <= 0, in_ready <= 1. The input offered that cycle is discarded even if in_fire. Flush has priority over every load/accept. Payload fields need not clear.
- Control gating (combinational on outputs): regwriteout, memreadout, memwriteout, branchout = stored bit & out_valid; memtoregout likewise. A bubble never writes the register file or memory.
- pcsrc = branchout & zerout (& out_valid when BRANCH_GATED=1, implicit via gated branchout).
- Data outputs (addsumout, aluresout, rd2out, zerout, rdout) show the main payload regardless of valid. They hold value while out_valid & !out_ready (stable under backpressure).
- Reset mid-transfer: all entries lost immediately, no glitch-free requirement on outputs during assertion.

Test Plan:
- Reset: assert reset_n=0 mid-stream with both entries full -> out_valid=0, in_ready=1, pcsrc=0, all outputs 0 without a clock edge.
- Stream: out_ready=1, push alures=0x10,0x20,0x30 back-to-back -> appear on aluresout on cycles 1,2,3 after each accept, out_valid continuous.
- Backpressure: out_ready=0, push A=0x1,B=0x2,C=0x3 -> A,B accepted, in_ready=0 after B, C held. Raise out_ready -> A,B,C delivered in order, no loss or duplication.
- Flush: both entries full, assert flush with in_valid=1 (memwrite=1) -> next cycle out_valid=0, memwriteout=0, in_ready=1. Flushed payload is never output.
- Branch: transaction branch=1, zero=1, addsum=0x400 -> pcsrc=1 with addsumout=0x400 for exactly the cycles it is out_valid. With zero=0 -> pcsrc=0.
- Forwarding: rd=0, regwrite=1 -> fwd_en=0. rd=7, regwrite=1 -> fwd_en=1, fwd_rd=7. Bubble -> regwriteout=0, fwd_en=0.

Source files
------------

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem_stage
//  Brief    : EX/MEM pipeline stage with a 2-entry skid buffer, a valid/ready
//             handshake on both sides, synchronous flush and pcsrc/forwarding.
//  Revision : 1.0 - initial release
// ============================================================================
module ex_mem_stage #(
   parameter int DATA_W       = 64,
   parameter int REG_ADDR_W   = 5,
   parameter bit BRANCH_GATED = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     addsum,
   input  logic [DATA_W-1:0]     alures,
   input  logic                  zero,
   input  logic [DATA_W-1:0]     rd2,
   input  logic [REG_ADDR_W-1:0] rd,
   input  logic                  regwrite,
   input  logic                  memtoreg,
   input  logic                  branch,
   input  logic                  memread,
   input  logic                  memwrite,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     addsumout,
   output logic [DATA_W-1:0]     aluresout,
   output logic [DATA_W-1:0]     rd2out,
   output logic                  zerout,
   output logic [REG_ADDR_W-1:0] rdout,
   output logic                  regwriteout,
   output logic                  memtoregout,
   output logic                  branchout,
   output logic                  memreadout,
   output logic                  memwriteout,
   output logic                  pcsrc,
   output logic [REG_ADDR_W-1:0] fwd_rd,
   output logic                  fwd_en
);

   localparam int c_PL_W = 3*DATA_W + REG_ADDR_W + 6;

   logic              r_main_valid;
   logic              r_skid_valid;
   logic [c_PL_W-1:0] r_main_pl;
   logic [c_PL_W-1:0] r_skid_pl;

   logic              w_in_fire;
   logic              w_out_fire;
   logic              w_main_load;
   logic [c_PL_W-1:0] w_in_pl;

   logic              w_regwrite;
   logic              w_memtoreg;
   logic              w_branch;
   logic              w_memread;
   logic              w_memwrite;

   assign w_in_pl = {addsum, alures, zero, rd2, rd,
                     regwrite, memtoreg, branch, memread, memwrite};

   assign in_ready    = ~r_skid_valid;
   assign out_valid   = r_main_valid;
   assign w_in_fire   = in_valid & in_ready;
   assign w_out_fire  = r_main_valid & out_ready;
   assign w_main_load = ~r_main_valid | w_out_fire;

   // Skid entry is always older than the concurrent input, so it moves to main first.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_main_pl    <= '0;
         r_skid_pl    <= '0;
      end else if (flush) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (w_main_load) begin
         if (r_skid_valid) begin
            r_main_valid <= 1'b1;
            r_main_pl    <= r_skid_pl;
            if (w_in_fire) begin
               r_skid_pl <= w_in_pl;
            end else begin
               r_skid_valid <= 1'b0;
            end
         end else if (w_in_fire) begin
            r_main_valid <= 1'b1;
            r_main_pl    <= w_in_pl;
         end else begin
            r_main_valid <= 1'b0;
         end
      end else if (w_in_fire) begin
         r_skid_valid <= 1'b1;
         r_skid_pl    <= w_in_pl;
      end
   end

   assign {addsumout, aluresout, zerout, rd2out, rdout,
           w_regwrite, w_memtoreg, w_branch, w_memread, w_memwrite} = r_main_pl;

   // Bubbles must never write the register file or memory.
   assign regwriteout = w_regwrite & r_main_valid;
   assign memtoregout = w_memtoreg & r_main_valid;
   assign branchout   = w_branch   & r_main_valid;
   assign memreadout  = w_memread  & r_main_valid;
   assign memwriteout = w_memwrite & r_main_valid;

   generate
      if (BRANCH_GATED) begin : g_pcsrc_gated
         assign pcsrc = branchout & zerout;
      end else begin : g_pcsrc_raw
         assign pcsrc = w_branch & zerout;
      end
   endgenerate

   assign fwd_rd = rdout;
   assign fwd_en = regwriteout & (rdout != '0);

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_mem_stage
//  Brief    : Directed self-checking bench for ex_mem_stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage;

   localparam int DATA_W     = 64;
   localparam int REG_ADDR_W = 5;

   logic                  clk = 1'b0;
   logic                  reset_n;
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_W-1:0]     addsum;
   logic [DATA_W-1:0]     alures;
   logic                  zero;
   logic [DATA_W-1:0]     rd2;
   logic [REG_ADDR_W-1:0] rd;
   logic                  regwrite, memtoreg, branch, memread, memwrite;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_W-1:0]     addsumout, aluresout, rd2out;
   logic                  zerout;
   logic [REG_ADDR_W-1:0] rdout;
   logic                  regwriteout, memtoregout, branchout, memreadout, memwriteout;
   logic                  pcsrc;
   logic [REG_ADDR_W-1:0] fwd_rd;
   logic                  fwd_en;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ex_mem_stage #(
      .DATA_W      (DATA_W),
      .REG_ADDR_W  (REG_ADDR_W),
      .BRANCH_GATED(1'b1)
   ) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .addsum(addsum), .alures(alures), .zero(zero), .rd2(rd2), .rd(rd),
      .regwrite(regwrite), .memtoreg(memtoreg), .branch(branch),
      .memread(memread), .memwrite(memwrite),
      .out_valid(out_valid), .out_ready(out_ready),
      .addsumout(addsumout), .aluresout(aluresout), .rd2out(rd2out),
      .zerout(zerout), .rdout(rdout),
      .regwriteout(regwriteout), .memtoregout(memtoregout), .branchout(branchout),
      .memreadout(memreadout), .memwriteout(memwriteout),
      .pcsrc(pcsrc), .fwd_rd(fwd_rd), .fwd_en(fwd_en)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      addsum = '0; alures = '0; zero = 1'b0; rd2 = '0; rd = '0;
      regwrite = 1'b0; memtoreg = 1'b0; branch = 1'b0; memread = 1'b0; memwrite = 1'b0;
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready",  in_ready,  1);
      check("rst_aluresout", aluresout, 0);
      check("rst_pcsrc",     pcsrc,     0);
      step();
      reset_n = 1'b1;

      // Back-to-back stream with out_ready held high.
      out_ready = 1'b1; in_valid = 1'b1;
      alures = 64'h10; step();
      check("str_v0", out_valid, 1); check("str_d0", aluresout, 64'h10);
      alures = 64'h20; step();
      check("str_v1", out_valid, 1); check("str_d1", aluresout, 64'h20);
      alures = 64'h30; step();
      check("str_v2", out_valid, 1); check("str_d2", aluresout, 64'h30);
      check("str_rdy", in_ready, 1);
      in_valid = 1'b0; step();
      check("str_drain", out_valid, 0);

      // Backpressure: A and B held, C stalled, then in-order drain.
      out_ready = 1'b0; in_valid = 1'b1;
      alures = 64'h1; step();
      check("bp_A_rdy", in_ready, 1); check("bp_A_d", aluresout, 64'h1);
      alures = 64'h2; step();
      check("bp_B_rdy", in_ready, 0); check("bp_B_hold", aluresout, 64'h1);
      alures = 64'h3; step();
      check("bp_C_rdy", in_ready, 0); check("bp_C_hold", aluresout, 64'h1);
      check("bp_C_v", out_valid, 1);
      out_ready = 1'b1; step();
      check("bp_out_B", aluresout, 64'h2); check("bp_rdy2", in_ready, 1);
      step();
      check("bp_out_C", aluresout, 64'h3); check("bp_v_C", out_valid, 1);
      in_valid = 1'b0; step();
      check("bp_empty", out_valid, 0);

      // Flush with both entries full and a memwrite offered.
      out_ready = 1'b0; in_valid = 1'b1;
      alures = 64'h50; step();
      alures = 64'h60; step();
      check("fl_full", in_ready, 0);
      flush = 1'b1; memwrite = 1'b1; alures = 64'h70; step();
      check("fl_v",   out_valid,   0);
      check("fl_mw",  memwriteout, 0);
      check("fl_rdy", in_ready,    1);
      // Flush must also discard an input that actually fires.
      step();
      check("fl_fire_v", out_valid, 0);
      flush = 1'b0; in_valid = 1'b0; memwrite = 1'b0; out_ready = 1'b1; step();
      check("fl_nothing", out_valid, 0);

      // Branch taken, then bubble, then not-taken.
      in_valid = 1'b1; branch = 1'b1; zero = 1'b1; addsum = 64'h400; step();
      check("br_pcsrc", pcsrc, 1); check("br_target", addsumout, 64'h400);
      in_valid = 1'b0; step();
      check("br_bubble_pcsrc", pcsrc, 0); check("br_bubble_bo", branchout, 0);
      in_valid = 1'b1; zero = 1'b0; step();
      check("br_nt_pcsrc", pcsrc, 0); check("br_nt_bo", branchout, 1);

      // Forwarding.
      branch = 1'b0; regwrite = 1'b1; rd = 5'd0; step();
      check("fw_x0_en", fwd_en, 0); check("fw_x0_rw", regwriteout, 1);
      rd = 5'd7; step();
      check("fw_r7_en", fwd_en, 1); check("fw_r7_rd", fwd_rd, 7);
      in_valid = 1'b0; step();
      check("fw_bub_rw", regwriteout, 0); check("fw_bub_en", fwd_en, 0);
      check("fw_bub_rd", rdout, 7);

      // Asynchronous reset with both entries holding a taken branch.
      out_ready = 1'b0; in_valid = 1'b1; branch = 1'b1; zero = 1'b1;
      alures = 64'hAA; rd = 5'd9; step(); step();
      check("ar_pre_pcsrc", pcsrc, 1); check("ar_pre_rdy", in_ready, 0);
      reset_n = 1'b0; #2;
      check("ar_v",     out_valid, 0);
      check("ar_rdy",   in_ready,  1);
      check("ar_pcsrc", pcsrc,     0);
      check("ar_alu",   aluresout, 0);
      check("ar_rd",    rdout,     0);
      check("ar_fwd",   fwd_en,    0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
